// File: rtl/bcd_arb_4.sv
// Round-robin arbiter that lets four requesters share one binary-to-BCD converter,
// with one transaction in flight and a sticky timeout flag for a stalled converter.
module bcd_arb_4 #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [32*N_REQ-1:0]    req_data_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [39:0]            rsp_data_o,
    output logic [N_REQ-1:0]       rsp_valid_o,
    input  logic [N_REQ-1:0]       rsp_ready_i,
    output logic [31:0]            conv_bin_data_o,
    output logic                   conv_bin_valid_o,
    input  logic                   conv_bin_ready_i,
    input  logic [39:0]            conv_bcd_data_i,
    input  logic                   conv_bcd_valid_i,
    output logic                   conv_bcd_ready_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t         state;
    logic [GW-1:0]  last_grant;
    logic [31:0]    operand;
    logic [CW-1:0]  cnt;
    logic [GW-1:0]  win;
    logic [GW-1:0]  idx;
    logic           found;

    // Rotating priority: search upward starting just past the previous owner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = GW'((int'(last_grant) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Accept is combinational so the winner sees ready in its request cycle;
    // gated by reset so nothing is accepted while reset is held.
    assign req_ready_o      = (rstn_i && state == IDLE && found) ? (N_REQ'(1) << win) : '0;
    assign rsp_valid_o      = (state == DELIVER) ? (N_REQ'(1) << grant_id_o) : '0;
    assign conv_bin_valid_o = (state == ISSUE);
    assign conv_bcd_ready_o = (state == WAIT);
    assign conv_bin_data_o  = operand;
    assign busy_o           = (state != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            grant_id_o <= '0;
            operand    <= '0;
            rsp_data_o <= '0;
            err_o      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        operand    <= req_data_i[32*int'(win) +: 32];
                        grant_id_o <= win;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (conv_bin_ready_i) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the expiry cycle wins over the timeout.
                    if (conv_bcd_valid_i) begin
                        rsp_data_o <= conv_bcd_data_i;
                        state      <= DELIVER;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_o      <= 1'b1;
                        rsp_data_o <= '1;
                        state      <= DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    if (rsp_ready_i[grant_id_o]) begin
                        last_grant <= grant_id_o;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_arb_4.sv
// Directed and randomized bench for bcd_arb_4: a latency-programmable converter model
// plus a round-robin/BCD reference model kept at the transaction level.
module tb_bcd_arb_4;
    logic         clk;
    logic         rstn;
    logic [127:0] req_data;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready_o;
    logic [39:0]  rsp_data_o;
    logic [3:0]   rsp_valid_o;
    logic [3:0]   rsp_ready;
    logic [31:0]  conv_bin_data_o;
    logic         conv_bin_valid_o;
    logic         conv_bin_ready;
    logic [39:0]  conv_bcd_data;
    logic         conv_bcd_valid;
    logic         conv_bcd_ready_o;
    logic [1:0]   grant_id_o;
    logic         busy_o;
    logic         err_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd [4];
    int          m_last;
    bit          m_err;

    int          conv_lat;
    bit          conv_hang;
    logic        pend;
    int          cnt_c;

    bcd_arb_4 dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .req_data_i       (req_data),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready),
        .conv_bin_data_o  (conv_bin_data_o),
        .conv_bin_valid_o (conv_bin_valid_o),
        .conv_bin_ready_i (conv_bin_ready),
        .conv_bcd_data_i  (conv_bcd_data),
        .conv_bcd_valid_i (conv_bcd_valid),
        .conv_bcd_ready_o (conv_bcd_ready_o),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] bcd(input logic [31:0] v);
        logic [39:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Converter: result appears conv_lat cycles after the operand handshake.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend           <= 1'b0;
            cnt_c          <= 0;
            conv_bcd_valid <= 1'b0;
            conv_bcd_data  <= '0;
        end else begin
            if (conv_bcd_valid && conv_bcd_ready_o) conv_bcd_valid <= 1'b0;
            if (conv_bin_valid_o && conv_bin_ready) begin
                pend          <= 1'b1;
                cnt_c         <= conv_lat - 1;
                conv_bcd_data <= bcd(conv_bin_data_o);
            end else if (pend) begin
                if (conv_hang) pend <= 1'b0;
                else if (cnt_c == 0) begin
                    conv_bcd_valid <= 1'b1;
                    pend           <= 1'b0;
                end else cnt_c <= cnt_c - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [3:0] mask, input int lat, input bit hang,
                       input int bstall, input int rstall);
        int          w;
        int          cyc;
        int          iss;
        bit          got;
        logic [39:0] exp_d;
        logic [3:0]  oh;
        conv_lat       = lat;
        conv_hang      = hang;
        conv_bin_ready = (bstall == 0);
        rsp_ready      = '0;
        w = -1;
        for (int i = 1; i <= 4; i++)
            if (w < 0 && mask[(m_last + i) % 4]) w = (m_last + i) % 4;
        oh = 4'(1 << w);
        @(negedge clk);
        req_valid = mask;
        req_data  = {rd[3], rd[2], rd[1], rd[0]};
        #1 chk("req_ready", req_ready_o, oh);
        @(posedge clk);
        #1 req_data = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0; iss = 0; got = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (rsp_valid_o != 0) got = 1;
            else begin
                chk("ready_busy", req_ready_o, 0);
                if (conv_bin_valid_o) begin
                    chk("bin_data", conv_bin_data_o, rd[w]);
                    if (iss >= bstall) conv_bin_ready = 1'b1;
                    iss++;
                end
                @(posedge clk);
                cyc++;
            end
        end
        if (hang) begin
            exp_d = '1;
            m_err = 1'b1;
        end else exp_d = bcd(rd[w]);
        chk("rsp_seen", got, 1);
        chk("latency", cyc, hang ? 65 + bstall : 2 + lat + bstall);
        chk("rsp_valid", rsp_valid_o, oh);
        chk("rsp_data", rsp_data_o, exp_d);
        chk("grant_id", grant_id_o, w);
        chk("err", err_o, m_err);
        chk("busy", busy_o, 1);
        // Non-owner ready bits during the stall must be ignored.
        rsp_ready = (rstall != 0) ? ~oh : oh;
        for (int j = 0; j < rstall; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_data", rsp_data_o, exp_d);
            chk("hold_valid", rsp_valid_o, oh);
            chk("hold_req_ready", req_ready_o, 0);
        end
        rsp_ready = oh;
        @(posedge clk);
        #1 rsp_ready = '0;
        req_valid = '0;
        m_last = w;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("rsp_dropped", rsp_valid_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mk;
        rstn = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0;
        conv_bin_ready = 1'b0; conv_lat = 1; conv_hang = 1'b0;
        m_last = 3; m_err = 1'b0;
        for (int k = 0; k < 4; k++) rd[k] = 32'(k);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_bin_valid", conv_bin_valid_o, 0);
        chk("rst_bcd_ready", conv_bcd_ready_o, 0);
        chk("rst_grant", grant_id_o, 0);
        @(negedge clk) rstn = 1'b1;

        // All four continuously requesting: 0,1,2,3,0.
        for (int t = 0; t < 5; t++) txn(4'b1111, 3, 0, 0, 0);

        rd[0] = 32'd12345678;
        txn(4'b0001, 33, 0, 0, 0);
        rd[2] = 32'hFFFF_FFFF;
        txn(4'b0100, 4, 0, 0, 0);

        // Result on the expiry cycle takes priority over the timeout.
        rd[3] = 32'd987654321;
        txn(4'b1000, 63, 0, 0, 0);

        rd[1] = 32'd42;
        txn(4'b0010, 1, 1, 0, 0);
        rd[0] = 32'd7;
        txn(4'b0001, 2, 0, 0, 0);

        rd[1] = 32'd55555;
        txn(4'b0010, 3, 0, 5, 10);

        for (int t = 0; t < 12; t++) begin
            mk = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) rd[k] = $urandom;
            txn(mk, $urandom_range(1, 8), 0, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while waiting on a converter that never answers.
        @(negedge clk);
        rd[0] = $urandom;
        req_valid = 4'b0001;
        req_data = {rd[3], rd[2], rd[1], rd[0]};
        conv_hang = 1'b1;
        conv_bin_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("in_wait", conv_bcd_ready_o, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_rsp_valid", rsp_valid_o, 0);
        chk("arst_rsp_data", rsp_data_o, 0);
        chk("arst_req_ready", req_ready_o, 0);
        chk("arst_bin_valid", conv_bin_valid_o, 0);
        chk("arst_bcd_ready", conv_bcd_ready_o, 0);
        chk("arst_grant", grant_id_o, 0);
        req_valid = '0;
        @(negedge clk) rstn = 1'b1;
        m_last = 3; m_err = 1'b0;
        rd[0] = 32'd1000; rd[3] = 32'd3000;
        txn(4'b1001, 5, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_arb_4.md
BCD_ARB_4 -- requirements
Module: bcd_arb_4

Interface
REQ-001 Parameter N_REQ, 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter TIMEOUT, 64, maximum cycles allowed in WAIT before abort.
REQ-003 clk_i  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 req_data_i  input  128  binary operands; requester k on bits [32k+31:32k].
REQ-006 req_valid_i  input  4  per-requester operand valid.
REQ-007 req_ready_o  output  4  per-requester operand accept.
REQ-008 rsp_data_o  output  40  BCD result, shared by all requesters.
REQ-009 rsp_valid_o  output  4  per-requester result valid, one-hot or zero.
REQ-010 rsp_ready_i  input  4  per-requester result accept.
REQ-011 conv_bin_data_o  output  32  operand to the shared converter.
REQ-012 conv_bin_valid_o  output  1  operand valid to converter.
REQ-013 conv_bin_ready_i  input  1  converter ready for operand.
REQ-014 conv_bcd_data_i  input  40  converter result.
REQ-015 conv_bcd_valid_i  input  1  converter result valid.
REQ-016 conv_bcd_ready_o  output  1  result accept to converter.
REQ-017 grant_id_o  output  2  index of requester owning the current transaction.
REQ-018 busy_o  output  1  high in any state other than IDLE.
REQ-019 err_o  output  1  sticky timeout flag.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, DELIVER; exactly one transaction in flight.
REQ-021 Handshake on any channel completes on a cycle where valid and ready are both high.
REQ-022 IDLE: if any req_valid_i bit is high, the winner is the first set bit searching upward (mod 4) from last_grant+1; req_ready_o is high only on the winner bit, in that same cycle; all other req_ready_o bits are 0.
REQ-023 IDLE with winner: latch operand and winner index, update grant_id_o, next state ISSUE; with no request, stay IDLE.
REQ-024 req_ready_o is 0 in all states other than IDLE.
REQ-025 ISSUE: conv_bin_valid_o=1 with latched operand; on conv_bin_ready_i=1 go to WAIT, otherwise hold operand and valid.
REQ-026 WAIT: conv_bcd_ready_o=1; on conv_bcd_valid_i=1 capture conv_bcd_data_i into rsp_data_o and go to DELIVER.
REQ-027 WAIT timeout: a 6-bit counter clears on WAIT entry and increments each WAIT cycle; if it reaches TIMEOUT-1 with no result, set err_o, load rsp_data_o=40'hFF_FFFF_FFFF (invalid-BCD marker), go to DELIVER.
REQ-028 Result valid arriving in the same cycle as timeout expiry takes priority; err_o is not set.
REQ-029 DELIVER: rsp_valid_o[grant_id_o]=1, rsp_data_o stable; on rsp_ready_i[grant_id_o]=1, last_grant<=grant_id_o and go to IDLE; rsp_ready_i bits of non-owners are ignored.
REQ-030 conv_bin_valid_o is 0 outside ISSUE; conv_bcd_ready_o is 0 outside WAIT.
REQ-031 Requester deasserting req_valid_i before grant is never granted; no request is queued.
REQ-032 Fairness: a continuously requesting requester is granted within 4 transactions.
REQ-033 Latency, zero-wait converter and requester: operand accept to rsp_valid_o = 2 + converter latency cycles.
REQ-034 Illegal state encodings return to IDLE on the next clock.

Reset
REQ-035 rstn_i low asynchronously forces: state IDLE, last_grant=3 (requester 0 wins first), grant_id_o=0, rsp_data_o=0, rsp_valid_o=0, req_ready_o=0, conv_bin_valid_o=0, conv_bcd_ready_o=0, busy_o=0, err_o=0, timeout counter=0.
REQ-036 Reset mid-transaction discards the in-flight operand/result with no response issued; the converter is assumed reset by the same rstn_i.
REQ-037 err_o clears only on reset.

Verification
REQ-038 Single request: req0 valid, data 32'd12345678, converter model 33 cycles -> rsp_valid_o=4'b0001, rsp_data_o=40'h0012345678, err_o=0.
REQ-039 All four valid continuously, data 0,1,2,3 -> grants in order 0,1,2,3,0; each rsp_data_o equals its requester's value in BCD.
REQ-040 Max value 32'hFFFF_FFFF on req2 -> rsp_data_o=40'h4294967295 on rsp_valid_o[2] only.
REQ-041 Converter never returns result -> after 64 WAIT cycles rsp_data_o=40'hFF_FFFF_FFFF, err_o=1 and stays 1 through the next normal transaction.
REQ-042 Backpressure: conv_bin_ready_i low 5 cycles, rsp_ready_i[1] low 10 cycles -> conv_bin_data_o and rsp_data_o stable throughout, no extra req_ready_o pulse.
REQ-043 rstn_i low during WAIT -> all outputs at reset values same cycle; next request from req3 and req0 together grants req0.
